// File: rtl/fetch_pc_unit.sv
// Program-counter register and fetch-request stage: sequences PC+4 / redirect targets to instruction memory.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
//
// state         | meaning
// --------------+---------------------------------------------------------
// BOOT          | first cycle out of reset, no request issued
// FETCH         | normal fetching, PC advances on acceptance
// HOLD_REDIRECT | redirect target pending behind an unaccepted request
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iPCSrc,
    input  logic [31:0] iPCTarget,
    input  logic        iStall,
    input  logic        iFetchReady,
    output logic        oFetchValid,
    output logic [31:0] oFetchAddr,
    output logic        oFetchKill,
    output logic [31:0] oPC,
    output logic [31:0] oPCPlus4,
    output logic        oRedirect,
    output logic        oMisaligned
);

    typedef enum logic [1:0] {
        BOOT          = 2'd0,
        FETCH         = 2'd1,
        HOLD_REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        redirect_q, redirect_d;
    logic        misaligned_q, misaligned_d;
    logic [32:0] resolved;

    // Returns {misaligned, pc_value} for a target at the moment it is loaded into the PC.
    function automatic logic [32:0] resolve_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) return {1'b1, TRAP_VECTOR};
        else                 return {1'b0, t};
`else
        return {1'b0, t & 32'hFFFF_FFFC};
`endif
    endfunction

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pending_q    <= 32'h0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        redirect_d   = 1'b0;
        misaligned_d = 1'b0;
        // A fresh redirect always beats whatever is pending (newest wins).
        resolved     = resolve_target(iPCSrc ? iPCTarget : pending_q);

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (iPCSrc) begin
                    redirect_d = 1'b1;
                    if (iFetchReady) begin
                        pc_d         = resolved[31:0];
                        misaligned_d = resolved[32];
                    end else begin
                        pending_d = iPCTarget;
                        state_d   = HOLD_REDIRECT;
                    end
                end else if (iFetchReady && !iStall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HOLD_REDIRECT: begin
                if (iPCSrc) begin
                    redirect_d = 1'b1;
                    pending_d  = iPCTarget;
                end
                if (iFetchReady) begin
                    pc_d         = resolved[31:0];
                    misaligned_d = resolved[32];
                    state_d      = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign oFetchValid = (state_q != BOOT);
    assign oFetchAddr  = pc_q;
    assign oPC         = pc_q;
    assign oPCPlus4    = pc_q + 32'd4;
    assign oFetchKill  = (state_q == HOLD_REDIRECT) && iFetchReady;
    assign oRedirect   = redirect_q;
    assign oMisaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        stall = 1'b0;
    logic        ready = 1'b0;

    logic        o_valid, o_kill, o_redir, o_mis;
    logic [31:0] o_addr, o_pc, o_plus4;

    int checks = 0;
    int passes = 0;

    fetch_pc_unit #(.RESET_PC(RPC), .TRAP_VECTOR(TRAP)) dut (
        .iClk(clk), .iRst(rst), .iPCSrc(src), .iPCTarget(tgt), .iStall(stall),
        .iFetchReady(ready), .oFetchValid(o_valid), .oFetchAddr(o_addr),
        .oFetchKill(o_kill), .oPC(o_pc), .oPCPlus4(o_plus4),
        .oRedirect(o_redir), .oMisaligned(o_mis)
    );

    always #5 clk = ~clk;

    // Behavioural model: "booting", an optional pending target, and the PC value.
    logic        m_boot, m_has_pend, m_valid, m_redir, m_mis;
    logic [31:0] m_pend, m_pc;

    function automatic logic [32:0] m_apply(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        if (t % 4 != 0) return {1'b1, TRAP};
        return {1'b0, t};
`else
        return {1'b0, t - (t % 4)};
`endif
    endfunction

    task automatic model_reset();
        m_boot = 1; m_has_pend = 0; m_pend = 0; m_pc = RPC;
        m_valid = 0; m_redir = 0; m_mis = 0;
    endtask

    task automatic model_step();
        logic [32:0] r;
        logic [31:0] want;
        m_redir = 0; m_mis = 0;
        if (m_boot) begin
            m_boot = 0; m_valid = 1;
        end else if (m_has_pend) begin
            want = src ? tgt : m_pend;
            m_redir = src;
            if (ready) begin
                r = m_apply(want); m_pc = r[31:0]; m_mis = r[32]; m_has_pend = 0;
            end else begin
                m_pend = want;
            end
        end else if (src) begin
            m_redir = 1;
            if (ready) begin
                r = m_apply(tgt); m_pc = r[31:0]; m_mis = r[32];
            end else begin
                m_pend = tgt; m_has_pend = 1;
            end
        end else if (ready && !stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    function automatic logic [98:0] exp_vec();
        return {m_valid, m_pc, m_pc, m_pc + 32'd4, m_redir, m_mis};
    endfunction

    wire [98:0] dut_vec = {o_valid, o_addr, o_pc, o_plus4, o_redir, o_mis};
    wire        exp_kill = !m_boot && m_has_pend && ready;

    task automatic drive(input logic s, input logic [31:0] t, input logic st, input logic rd);
        src = s; tgt = t; stall = st; ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 1);
        rst = 1; model_reset();
        tick(); tick();
        checks++; if (dut_vec !== exp_vec()) $display("FAIL reset_vec got %h exp %h", dut_vec, exp_vec()); else passes++;
        checks++; if ({o_valid, o_kill, o_redir, o_mis, o_pc} !== {4'b0, RPC})
            $display("FAIL reset_vals got %b%b%b%b %h exp 0000 %h", o_valid, o_kill, o_redir, o_mis, o_pc, RPC); else passes++;
        rst = 0;
        #1;
        checks++; if (o_valid !== 1'b0) $display("FAIL boot_valid got %b exp 0", o_valid); else passes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_valid !== 1'b1 || o_addr !== RPC + 32'(i * 4))
                $display("FAIL boot_seq%0d got %b %h exp 1 %h", i, o_valid, o_addr, RPC + 32'(i * 4)); else passes++;
        end
    endtask

    task automatic test_redirect();
        drive(1, 32'h200, 0, 1); tick();
        drive(0, 0, 0, 1);
        checks++; if (o_addr !== 32'h200) $display("FAIL redir_setup got %h exp 00000200", o_addr); else passes++;
        drive(1, 32'h80, 0, 1); tick();
        drive(0, 0, 0, 1);
        checks++; if (o_addr !== 32'h80 || o_redir !== 1'b1)
            $display("FAIL redir_taken got %h %b exp 00000080 1", o_addr, o_redir); else passes++;
        tick();
        checks++; if (o_redir !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL redir_pulse got %h exp %h", dut_vec, exp_vec()); else passes++;
    endtask

    task automatic test_hold();
        drive(1, 32'h40, 0, 1); tick();
        for (int i = 0; i < 4; i++) begin
            drive(i == 0 || i == 2, (i < 2) ? 32'h400 : 32'h500, 0, 0);
            #1;
            checks++; if (o_kill !== 1'b0) $display("FAIL hold_kill_early%0d got %b exp 0", i, o_kill); else passes++;
            tick();
            checks++; if (o_addr !== 32'h40 || o_valid !== 1'b1 || dut_vec !== exp_vec())
                $display("FAIL hold_addr%0d got %h exp %h", i, dut_vec, exp_vec()); else passes++;
        end
        drive(0, 0, 0, 1);
        #1;
        checks++; if (o_kill !== 1'b1 || exp_kill !== 1'b1) $display("FAIL hold_kill got %b exp 1", o_kill); else passes++;
        tick();
        checks++; if (o_addr !== 32'h500 || o_kill !== 1'b0)
            $display("FAIL hold_apply got %h %b exp 00000500 0", o_addr, o_kill); else passes++;
    endtask

    task automatic test_stall();
        drive(1, 32'h10, 0, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1); tick();
            checks++; if (o_addr !== 32'h10) $display("FAIL stall%0d got %h exp 00000010", i, o_addr); else passes++;
        end
        drive(0, 0, 0, 1); tick();
        checks++; if (o_addr !== 32'h14 || dut_vec !== exp_vec())
            $display("FAIL stall_release got %h exp 00000014", o_addr); else passes++;
    endtask

    task automatic test_misalign();
        logic [31:0] want_pc;
        logic        want_mis;
`ifdef FETCH_MISALIGN_TRAP_EN
        want_pc = TRAP; want_mis = 1'b1;
`else
        want_pc = 32'h300; want_mis = 1'b0;
`endif
        drive(1, 32'h302, 0, 1); tick();
        drive(0, 0, 0, 1);
        checks++; if (o_pc !== want_pc || o_mis !== want_mis || o_redir !== 1'b1)
            $display("FAIL misalign got %h %b exp %h %b", o_pc, o_mis, want_pc, want_mis); else passes++;
        tick();
        checks++; if (o_mis !== 1'b0) $display("FAIL misalign_pulse got %b exp 0", o_mis); else passes++;
    endtask

    task automatic test_wrap();
        drive(1, 32'hFFFF_FFFC, 0, 1); tick();
        drive(0, 0, 0, 1);
        checks++; if (o_plus4 !== 32'h0) $display("FAIL wrap_plus4 got %h exp 00000000", o_plus4); else passes++;
        tick();
        checks++; if (o_pc !== 32'h0) $display("FAIL wrap_pc got %h exp 00000000", o_pc); else passes++;
    endtask

    task automatic test_reset_mid_hold();
        drive(1, 32'h700, 0, 0); tick();
        drive(0, 0, 0, 0);
        #2; rst = 1; ready = 1; #1;
        model_reset();
        checks++; if ({o_valid, o_kill, o_redir, o_mis, o_pc} !== {4'b0, RPC})
            $display("FAIL rst_async got %b%b%b%b %h exp 0000 %h", o_valid, o_kill, o_redir, o_mis, o_pc, RPC); else passes++;
        tick();
        rst = 0;
        tick();
        checks++; if (o_valid !== 1'b1 || o_addr !== RPC) $display("FAIL rst_first got %b %h exp 1 %h", o_valid, o_addr, RPC); else passes++;
        tick();
        checks++; if (o_addr !== RPC + 32'd4) $display("FAIL rst_no_pending got %h exp %h", o_addr, RPC + 32'd4); else passes++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 5) == 0, $urandom, ($urandom % 4) == 0, ($urandom % 3) != 0);
            #1;
            checks++; if (o_kill !== exp_kill) begin
                $display("FAIL rnd_kill%0d got %b exp %b", i, o_kill, exp_kill); errs++; end else passes++;
            tick();
            checks++; if (dut_vec !== exp_vec()) begin
                $display("FAIL rnd_vec%0d got %h exp %h", i, dut_vec, exp_vec()); errs++; end else passes++;
            if (errs > 20) break;
        end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_hold();
        test_stall();
        test_misalign();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter register and fetch-request stage. It consumes the redirect target produced by the PC adder together with the taken/jump decision. It sequences the next fetch address (PC+4 or redirect) into instruction memory through a valid/ready handshake. It also supplies the current PC to the pipeline, and resolves stalls, redirects and back-pressure arriving in the same cycle.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (only with the Configuration macro).
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iPCSrc  in  1  redirect request: a taken branch or jump has been resolved.
- iPCTarget  in  32  redirect target from the PC adder.
- iStall  in  1  hazard hold; inhibits PC advance only.
- iFetchReady  in  1  instruction memory accepts the current request.
- oFetchValid  out  1  fetch request valid.
- oFetchAddr  out  32  fetch address; always equals oPC.
- oFetchKill  out  1  the request accepted this cycle is wrong-path and must be dropped.
- oPC  out  32  current PC.
- oPCPlus4  out  32  oPC + 4, modulo 2^32.
- oRedirect  out  1  one-cycle flush pulse to IF/ID.
- oMisaligned  out  1  one-cycle misaligned-target pulse.

## Operation
- States:
  - BOOT: entered from reset; lasts exactly one cycle.
  - FETCH: normal fetching.
  - HOLD_REDIRECT: a target is pending behind an unaccepted request.
- Reset values: state BOOT, PC = RESET_PC, pending = 0, oFetchValid = 0, oFetchKill = 0, oRedirect = 0, oMisaligned = 0.
- BOOT → FETCH unconditionally. All iPCSrc and iStall inputs are ignored while in BOOT.
- oFetchValid = 1 in FETCH and in HOLD_REDIRECT.
- Handshake rule: while oFetchValid && !iFetchReady, oFetchAddr is held stable.
- FETCH, priority order:
  1. iPCSrc && iFetchReady: PC ← target; oRedirect = 1 next cycle.
  2. iPCSrc && !iFetchReady: pending ← target; go to HOLD_REDIRECT; oRedirect = 1 next cycle; PC holds.
  3. iFetchReady && !iStall: PC ← PC+4.
  4. Otherwise: PC holds. A request accepted while iStall = 1 is re-issued at the same address.
- HOLD_REDIRECT:
  - A new iPCSrc overwrites pending (newest wins). oRedirect pulses again.
  - On iFetchReady: oFetchKill = 1 in that same cycle (combinational), PC ← pending, go to FETCH.
  - iStall is ignored in this state.
  - If iPCSrc and iFetchReady are both high, the new iPCSrc target is the one loaded.
- PC+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Reset asserted in any state returns to the reset values immediately; the pending target is discarded.

## Timing
- Redirect latency: iPCSrc sampled at edge N. oFetchAddr shows the target from cycle N+1 if accepted at N; otherwise it shows it the cycle after the first acceptance in HOLD_REDIRECT.
- oRedirect and oMisaligned are registered one-cycle pulses, aligned to the cycle the new PC first appears or to the first HOLD_REDIRECT cycle.
- oPC, oFetchAddr and oPCPlus4 are driven from the PC register (oPCPlus4 via an adder) with no input-to-output combinational path.
- oFetchKill is the only combinational output. It depends on the state and iFetchReady.
- First request after reset deassertion: the second rising edge (the BOOT cycle has oFetchValid = 0).

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A target with [1:0] != 2'b00, at the moment it is loaded into PC, loads TRAP_VECTOR instead.
  - oMisaligned pulses alongside oRedirect.
  - A misaligned pending target is checked when applied, not when latched.
- Not defined:
  - Target bits [1:0] are forced to 2'b00 on load.
  - oMisaligned is tied to 0.

## Test plan
- Reset with RESET_PC = 32'h100, release, iFetchReady = 1 → oFetchValid = 0 for one cycle, then oFetchAddr 0x100, 0x104, 0x108 on consecutive cycles.
- PC = 0x200, iFetchReady = 1, iPCSrc = 1 with target 0x80 → next cycle oFetchAddr = 0x80 and oRedirect = 1 for exactly one cycle.
- iFetchReady = 0 at PC 0x40, iPCSrc target 0x400, then iPCSrc target 0x500 two cycles later, ready raised after 4 cycles:
  - oFetchAddr holds 0x40 throughout;
  - oFetchKill = 1 on acceptance;
  - next oFetchAddr = 0x500.
- iStall = 1 for 3 cycles at PC 0x10 with ready = 1 → oFetchAddr stays 0x10; 0x14 appears one cycle after stall drops.
- Target 0x302:
  - macro on → PC = TRAP_VECTOR (0x100), oMisaligned pulse;
  - macro off → PC = 0x300, oMisaligned = 0.
- Assert iRst mid-HOLD_REDIRECT, release → outputs at reset values, first fetch at RESET_PC, pending target never fetched.
